// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types, defaults and width helper for the multi-port register file
package rf_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    localparam int RF_DW_DEF    = 32;
    localparam int RF_DEPTH_DEF = 32;

    function automatic int rf_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/rf_multiport_if.sv
// rtl/rf_multiport_if.sv - read, write and issue bus between datapath and register file
interface rf_multiport_if
    import rf_pkg::*;
#(
    parameter int DW     = RF_DW_DEF,
    parameter int DEPTH  = RF_DEPTH_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    localparam int AW = rf_aw(DEPTH);

    logic [NUM_RD*AW-1:0] rd_addr_i;
    logic [NUM_RD*DW-1:0] rd_data_o;
    logic [NUM_RD-1:0]    rd_pend_o;
    logic [NUM_WR-1:0]    we_i;
    logic [NUM_WR*AW-1:0] wr_addr_i;
    logic [NUM_WR*DW-1:0] wr_data_i;
    logic                 iss_i;
    logic [AW-1:0]        iss_addr_i;

    modport master (
        output rd_addr_i, we_i, wr_addr_i, wr_data_i, iss_i, iss_addr_i,
        input  rd_data_o, rd_pend_o
    );

    modport slave (
        input  rd_addr_i, we_i, wr_addr_i, wr_data_i, iss_i, iss_addr_i,
        output rd_data_o, rd_pend_o
    );

endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-entry pending-write bits; set wins over a same-cycle clear
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int  DEPTH  = RF_DEPTH_DEF,
    parameter int  NUM_WR = 1,
    localparam int AW     = rf_aw(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 sync_clr_i,
    input  logic                 set_i,
    input  logic [AW-1:0]        set_addr_i,
    input  logic [NUM_WR-1:0]    clr_i,
    input  logic [NUM_WR*AW-1:0] clr_addr_i,
    output logic [DEPTH-1:0]     pend_o
);

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        if (sync_clr_i) begin
            pend_d = '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (clr_i[k]) pend_d[clr_addr_i[k*AW +: AW]] = 1'b0;
            end
            // Applied after the clears so a same-cycle issue keeps the entry pending
            if (set_i) pend_d[set_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pend_q <= '0;
        else         pend_q <= pend_d;
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - multi-port register file with clear sequencer; RF_WR_BYPASS_EN adds write forwarding
module rf_multiport
    import rf_pkg::*;
#(
    parameter int DW       = RF_DW_DEF,
    parameter int DEPTH    = RF_DEPTH_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic ready_o,
    rf_multiport_if.slave bus
);

    localparam int AW = rf_aw(DEPTH);

    rf_state_e        state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0] pend;
    logic             ready;
    logic             set_en;
    logic [AW-1:0]    ra;

    assign ready   = (state_q == RF_RUN);
    assign ready_o = ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            RF_CLEAR: begin
                if (clr_i) begin
                    ptr_d = '0;
                end else if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = RF_RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            RF_RUN: begin
                if (clr_i) begin
                    state_d = RF_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = RF_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RF_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Later write ports overwrite earlier ones, giving the highest port priority
    always_comb begin
        mem_d = mem_q;
        if (state_q == RF_CLEAR) begin
            mem_d[ptr_q] = '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (bus.we_i[k] && !((ZERO_REG != 0) && (bus.wr_addr_i[k*AW +: AW] == '0))) begin
                    mem_d[bus.wr_addr_i[k*AW +: AW]] = bus.wr_data_i[k*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign set_en = ready && bus.iss_i && !((ZERO_REG != 0) && (bus.iss_addr_i == '0));

    rf_scoreboard #(
        .DEPTH  (DEPTH),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .sync_clr_i (clr_i),
        .set_i      (set_en),
        .set_addr_i (bus.iss_addr_i),
        .clr_i      (ready ? bus.we_i : '0),
        .clr_addr_i (bus.wr_addr_i),
        .pend_o     (pend)
    );

    always_comb begin
        bus.rd_data_o = '0;
        bus.rd_pend_o = '0;
        ra            = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra = bus.rd_addr_i[p*AW +: AW];
            if (ready) begin
                bus.rd_data_o[p*DW +: DW] = mem_q[ra];
                bus.rd_pend_o[p]          = pend[ra];
`ifdef RF_WR_BYPASS_EN
                for (int k = 0; k < NUM_WR; k++) begin
                    if (bus.we_i[k] && (bus.wr_addr_i[k*AW +: AW] == ra)) begin
                        bus.rd_data_o[p*DW +: DW] = bus.wr_data_i[k*DW +: DW];
                        bus.rd_pend_o[p]          = 1'b0;
                    end
                end
`endif
                if ((ZERO_REG != 0) && (ra == '0)) bus.rd_data_o[p*DW +: DW] = '0;
            end
        end
    end

endmodule

// File: tb/tb_rf_multiport.sv
// tb/tb_rf_multiport.sv - scoreboard bench for rf_multiport against an array-based reference model
module tb_rf_multiport;

    localparam int DW       = 32;
    localparam int DEPTH    = 32;
    localparam int NUM_RD   = 2;
    localparam int NUM_WR   = 2;
    localparam int ZERO_REG = 1;
    localparam int AW       = 5;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic clr_i;
    logic ready_o;

    rf_multiport_if #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

    rf_multiport #(
        .DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .ready_o (ready_o),
        .bus     (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic                 rdy;
        logic [NUM_RD*DW-1:0] d;
        logic [NUM_RD-1:0]    pd;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    logic [DW-1:0] m_mem  [DEPTH];
    logic          m_pend [DEPTH];
    int            m_left;

    logic [AW-1:0]     s_rd [NUM_RD];
    logic [NUM_WR-1:0] s_we;
    logic [AW-1:0]     s_wa [NUM_WR];
    logic [DW-1:0]     s_wd [NUM_WR];
    logic              s_iss;
    logic [AW-1:0]     s_ia;
    logic              s_clr;

    task automatic check(input string name, input int port, input logic [DW-1:0] act, input logic [DW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s[%0d] at %0t: got %h, expected %h", name, port, $time, act, req);
        end
    endtask

    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ready", 0, DW'(ready_o), DW'(e.rdy));
            for (int p = 0; p < NUM_RD; p++) begin
                check("rd_data", p, bus.rd_data_o[p*DW +: DW], e.d[p*DW +: DW]);
                check("rd_pend", p, DW'(bus.rd_pend_o[p]), DW'(e.pd[p]));
            end
        end
    end

    task automatic idle();
        for (int p = 0; p < NUM_RD; p++) s_rd[p] = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            s_wa[k] = '0;
            s_wd[k] = '0;
        end
        s_we  = '0;
        s_iss = 1'b0;
        s_ia  = '0;
        s_clr = 1'b0;
    endtask

    task automatic model_reset();
        m_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
    endtask

    // Drive the staged inputs for one cycle, queue the expected outputs, then advance the model
    task automatic step();
        exp_t          e;
        logic [DW-1:0] d;
        logic          pd;
        for (int p = 0; p < NUM_RD; p++) bus.rd_addr_i[p*AW +: AW] = s_rd[p];
        for (int k = 0; k < NUM_WR; k++) begin
            bus.wr_addr_i[k*AW +: AW] = s_wa[k];
            bus.wr_data_i[k*DW +: DW] = s_wd[k];
        end
        bus.we_i       = s_we;
        bus.iss_i      = s_iss;
        bus.iss_addr_i = s_ia;
        clr_i          = s_clr;

        e     = '0;
        e.rdy = (m_left == 0);
        for (int p = 0; p < NUM_RD; p++) begin
            d  = '0;
            pd = 1'b0;
            if (e.rdy) begin
                d  = m_mem[s_rd[p]];
                pd = m_pend[s_rd[p]];
`ifdef RF_WR_BYPASS_EN
                for (int k = 0; k < NUM_WR; k++) begin
                    if (s_we[k] && s_wa[k] == s_rd[p]) begin
                        d  = (s_rd[p] == 0) ? '0 : s_wd[k];
                        pd = 1'b0;
                    end
                end
`endif
            end
            e.d[p*DW +: DW] = d;
            e.pd[p]         = pd;
        end
        exp_q.push_back(e);

        @(posedge clk_i);
        if (m_left == 0) begin
            if (s_clr) begin
                m_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) begin
                    m_mem[i]  = '0;
                    m_pend[i] = 1'b0;
                end
            end else begin
                for (int k = 0; k < NUM_WR; k++) if (s_we[k] && s_wa[k] != 0) m_mem[s_wa[k]] = s_wd[k];
                for (int k = 0; k < NUM_WR; k++) if (s_we[k]) m_pend[s_wa[k]] = 1'b0;
                if (s_iss && s_ia != 0) m_pend[s_ia] = 1'b1;
            end
        end else begin
            m_left = s_clr ? DEPTH : m_left - 1;
        end
        #1;
    endtask

    task automatic wait_ready();
        idle();
        for (int i = 0; i < 2 * DEPTH && m_left != 0; i++) step();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        idle();
        rst_ni = 1'b0;
        clr_i  = 1'b0;
        bus.rd_addr_i  = '0;
        bus.we_i       = '0;
        bus.wr_addr_i  = '0;
        bus.wr_data_i  = '0;
        bus.iss_i      = 1'b0;
        bus.iss_addr_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        model_reset();

        // Writes and issues during the initial sweep must be ignored
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            s_we    = 2'b01;
            s_wa[0] = AW'(i);
            s_wd[0] = 32'hBAD0_0000 + DW'(i);
            s_iss   = 1'b1;
            s_ia    = AW'(i);
            s_rd[0] = AW'(i);
            step();
        end
        for (int i = 0; i < DEPTH; i += 2) begin
            idle();
            s_rd[0] = AW'(i);
            s_rd[1] = AW'(i + 1);
            step();
        end

        idle(); s_we = 2'b01; s_wa[0] = 5; s_wd[0] = 32'hDEADBEEF; s_rd[0] = 5; step();
        idle(); s_rd[0] = 5; step();

        idle(); s_we = 2'b01; s_wa[0] = 0; s_wd[0] = 32'h1234; s_iss = 1'b1; s_ia = 0; s_rd[0] = 0; step();
        idle(); s_rd[0] = 0; s_rd[1] = 0; step();

        idle();
        s_we = 2'b11; s_wa[0] = 7; s_wd[0] = 32'h11; s_wa[1] = 7; s_wd[1] = 32'h22;
        s_iss = 1'b1; s_ia = 7; s_rd[0] = 7;
        step();
        idle(); s_rd[0] = 7; s_rd[1] = 7; step();

        idle(); s_iss = 1'b1; s_ia = 9; s_rd[1] = 9; step();
        repeat (3) begin idle(); s_rd[0] = 9; step(); end
        idle(); s_we = 2'b10; s_wa[1] = 9; s_wd[1] = 32'h99; s_rd[0] = 9; step();
        idle(); s_rd[0] = 9; step();

        idle(); s_clr = 1'b1; s_rd[0] = 5; step();
        wait_ready();
        for (int i = 0; i < DEPTH; i += 2) begin
            idle();
            s_rd[0] = AW'(i);
            s_rd[1] = AW'(i + 1);
            step();
        end

        idle(); s_we = 2'b01; s_wa[0] = 3; s_wd[0] = 32'hCAFE; step();
        idle(); s_clr = 1'b1; step();
        repeat (10) begin idle(); step(); end
        #1;
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        model_reset();
        idle(); s_rd[0] = 3; step();
        repeat (20) begin idle(); step(); end
        idle(); s_clr = 1'b1; step();
        wait_ready();

        // Narrow address range forces port collisions and scoreboard races
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int p = 0; p < NUM_RD; p++) s_rd[p] = AW'($urandom_range(0, 7));
            for (int k = 0; k < NUM_WR; k++) begin
                s_we[k] = ($urandom_range(0, 2) == 0);
                s_wa[k] = AW'($urandom_range(0, 7));
                s_wd[k] = $urandom;
            end
            s_iss = ($urandom_range(0, 2) == 0);
            s_ia  = AW'($urandom_range(0, 7));
            s_clr = ($urandom_range(0, 79) == 0);
            step();
        end

        idle();
        step();
        @(negedge clk_i);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
